code_loader: RTL and testbench

CODE_LOADER -- requirements
Module: code_loader

---
 rtl/code_loader.sv | 157 +++++++++++++++
 tb/tb_code_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_loader.sv
// Streams a program image into a 1024-word instruction buffer and holds the CPU in reset until the image is complete.
// Latency: a word is written on the edge that accepts it; unwritten tail words are zero-filled at one word per cycle.
// Backpressure: word_ready is high only while loading; it drops during zero-fill, in RUN and in IDLE.
module code_loader (
  input  logic             clk,
  input  logic [1:0]       rst_n,
  input  logic             start,
  input  logic             word_valid,
  input  logic [31:0]      word_data,
  input  logic             word_last,
  output logic             word_ready,
  output logic [32767:0]   input_code,
  output logic [1:0]       cpu_rst_n,
  output logic             busy,
  output logic             load_done,
  output logic [10:0]      word_count,
  output logic             trunc
);

  localparam int unsigned WORDS = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 11;

  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FILL = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  // The reset pin is two bits wide; any non-zero value counts as released.
  logic arst_n;
  assign arst_n = (rst_n != 2'b00);

  state_t             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               trunc_q, trunc_d;
  logic               wr_en;
  logic [DW-1:0]      wr_data;
  logic [WORDS*DW-1:0] code_q;

  logic               word_ready_q;
  logic               busy_q;
  logic               load_done_q;
  logic [1:0]         cpu_rst_q;

  logic               accept;
  logic               at_last_addr;

  // word_ready_q is high exactly in LOAD, so this is the valid/ready handshake.
  assign accept       = word_valid & word_ready_q;
  assign at_last_addr = (addr_q == LAST_ADDR);

  // Next-state and image-write decision for the load sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    trunc_d = trunc_q;
    wr_en   = 1'b0;
    wr_data = word_data;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          count_d = '0;
          trunc_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
          if (at_last_addr) begin
            // Buffer is full: run whether or not the producer flagged the end.
            // addr is left at the top so it never wraps inside one load.
            state_d = S_RUN;
            trunc_d = ~word_last;
          end else begin
            addr_d = addr_q + AW'(1);
            if (word_last) begin
              state_d = S_FILL;
            end
          end
        end
      end
      S_FILL: begin
        // Zero the tail so no word of an earlier program survives a shorter reload.
        wr_en   = 1'b1;
        wr_data = '0;
        if (at_last_addr) begin
          state_d = S_RUN;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_RUN: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          count_d = '0;
          trunc_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state, counters and registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      trunc_q      <= 1'b0;
      word_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      cpu_rst_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      trunc_q      <= trunc_d;
      word_ready_q <= (state_d == S_LOAD);
      busy_q       <= (state_d == S_LOAD) || (state_d == S_FILL);
      load_done_q  <= (state_d == S_RUN);
      // The CPU leaves reset on the same edge that writes the final image word.
      cpu_rst_q    <= (state_d == S_RUN) ? 2'b01 : 2'b00;
    end
  end

  // Instruction image storage, one word written per cycle at most.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      code_q <= '0;
    end else if (wr_en) begin
      code_q[{addr_q, 5'b00000} +: DW] <= wr_data;
    end
  end

  assign word_ready = word_ready_q;
  assign input_code = code_q;
  assign cpu_rst_n  = cpu_rst_q;
  assign busy       = busy_q;
  assign load_done  = load_done_q;
  assign word_count = count_q;
  assign trunc      = trunc_q;

endmodule

// File: tb/tb_code_loader.sv
// Directed and randomized program loads checked against an image-level reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Every comparison is an immediate assertion that counts passes and reports failures.
module tb_code_loader;

  logic           clk = 1'b0;
  logic [1:0]     rst_n;
  logic           start;
  logic           word_valid;
  logic [31:0]    word_data;
  logic           word_last;
  logic           word_ready;
  logic [32767:0] input_code;
  logic [1:0]     cpu_rst_n;
  logic           busy;
  logic           load_done;
  logic [10:0]    word_count;
  logic           trunc;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: the expected image as an array plus expected status.
  logic [31:0] ref_img [1024];
  int          ref_count;
  bit          ref_trunc;
  logic [31:0] acc_q [$];
  logic [31:0] tbl [4];
  bit          phase_ok;

  code_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_last  (word_last),
    .word_ready (word_ready),
    .input_code (input_code),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .load_done  (load_done),
    .word_count (word_count),
    .trunc      (trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_img(input string tag);
    logic [32767:0] e;
    int first;
    e = '0;
    for (int k = 0; k < 1024; k++) e[k*32 +: 32] = ref_img[k];
    n_chk++;
    assert (input_code === e) n_pass++;
    else begin
      n_fail++;
      first = 0;
      for (int k = 1023; k >= 0; k--) if (input_code[k*32 +: 32] !== ref_img[k]) first = k;
      $error("FAIL %s word %0d observed=%h expected=%h", tag, first,
             input_code[first*32 +: 32], ref_img[first]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 1024; k++) ref_img[k] = 32'h0;
    ref_count = 0;
    ref_trunc = 1'b0;
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_done"},  load_done, 1);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_ready"}, word_ready, 0);
    chk({tag, "_cpu"},   cpu_rst_n, 2'b01);
    chk({tag, "_count"}, word_count, ref_count);
    chk({tag, "_trunc"}, trunc, ref_trunc);
    chk_img({tag, "_img"});
  endtask

  // Called on a falling edge in IDLE or RUN; returns on the falling edge after LOAD is entered.
  task automatic do_start();
    start = 1'b1;
    word_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    acc_q.delete();
    phase_ok = 1'b1;
    chk("start_ready", word_ready, 1);
    chk("start_busy",  busy, 1);
    chk("start_cpu",   cpu_rst_n, 2'b00);
    chk("start_count", word_count, 0);
    chk("start_trunc", trunc, 0);
    chk("start_done",  load_done, 0);
  endtask

  // One LOAD cycle: drive inputs, record the word if the handshake completes.
  task automatic drive_one(input logic v, input logic [31:0] d, input logic l, input logic s);
    word_valid = v;
    word_data  = d;
    word_last  = l;
    start      = s;
    if (!(cpu_rst_n === 2'b00 && busy === 1'b1)) phase_ok = 1'b0;
    if (v && word_ready === 1'b1) acc_q.push_back(d);
    @(negedge clk);
  endtask

  // mode: 0 always valid, 1 alternating, 2 random gaps. dmode: 0 random, 1 index, 2 all ones, 3 table.
  task automatic load_words(input int n, input bit last_at_end, input int mode, input int dmode,
                            input string tag);
    int guard;
    int k;
    int i;
    logic v;
    logic [31:0] d;
    guard = 0;
    k = 0;
    while (acc_q.size() < n && guard < 5000) begin
      i = acc_q.size();
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = ($urandom_range(0, 9) < 6);
      endcase
      case (dmode)
        0:       d = $urandom;
        1:       d = 32'(i);
        2:       d = 32'hFFFF_FFFF;
        default: d = tbl[i % 4];
      endcase
      drive_one(v, d, v ? (last_at_end && i == n - 1) : 1'($urandom),
                1'($urandom_range(0, 3) == 0));
      guard++;
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
    start      = 1'b0;
    chk({tag, "_accepted"}, acc_q.size(), n);
    // Zero-fill phase: inputs are noise here and must be ignored.
    while (load_done !== 1'b1 && k < 2100) begin
      if (!(cpu_rst_n === 2'b00 && busy === 1'b1 && word_ready === 1'b0)) phase_ok = 1'b0;
      word_valid = 1'($urandom);
      word_data  = $urandom;
      start      = 1'($urandom);
      @(negedge clk);
      k++;
    end
    word_valid = 1'b0;
    start      = 1'b0;
    chk({tag, "_fill_cycles"}, k, (n >= 1024) ? 0 : 1024 - n);
    chk({tag, "_cpu_in_reset"}, phase_ok, 1);
    for (int j = 0; j < 1024; j++) ref_img[j] = (j < acc_q.size()) ? acc_q[j] : 32'h0;
    ref_count = acc_q.size();
    ref_trunc = (n == 1024) && !last_at_end;
    check_run(tag);
  endtask

  initial begin
    int n;
    bit l;
    rst_n      = 2'b11;
    start      = 1'b0;
    word_valid = 1'b0;
    word_data  = 32'h0;
    word_last  = 1'b0;
    model_reset();
    #2 rst_n = 2'b00;
    word_valid = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", word_ready, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  load_done, 0);
    chk("rst_cpu",   cpu_rst_n, 2'b00);
    chk("rst_count", word_count, 0);
    chk("rst_trunc", trunc, 0);
    chk_img("rst_img");

    // Release with a random non-zero code; words offered in IDLE are ignored.
    start = 1'b0;
    rst_n = 2'($urandom_range(1, 3));
    for (int c = 0; c < 4; c++) begin
      word_valid = 1'b1;
      word_data  = $urandom;
      word_last  = 1'($urandom);
      @(negedge clk);
    end
    word_valid = 1'b0;
    chk("idle_busy",  busy, 0);
    chk("idle_ready", word_ready, 0);
    chk("idle_count", word_count, 0);
    chk_img("idle_img");

    // Short three-instruction program followed by zero fill.
    tbl[0] = 32'h0000_0013;
    tbl[1] = 32'h0010_0093;
    tbl[2] = 32'h0020_8133;
    tbl[3] = 32'h0;
    do_start();
    load_words(3, 1'b1, 0, 3, "prog3");

    // Words offered in RUN without start are ignored.
    for (int c = 0; c < 8; c++) begin
      word_valid = 1'b1;
      word_data  = $urandom;
      word_last  = 1'($urandom);
      @(negedge clk);
    end
    word_valid = 1'b0;
    check_run("run_ignore");

    // Alternating valid: only the valid cycles count.
    do_start();
    drive_one(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    drive_one(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    drive_one(1'b1, 32'hA5A5_0002, 1'b0, 1'b0);
    drive_one(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("toggle_count", word_count, 2);
    load_words(5, 1'b1, 1, 0, "toggle");

    // Full buffer without word_last: truncation, no zero fill.
    do_start();
    load_words(1024, 1'b0, 0, 1, "full_trunc");

    // Reload: all-ones image replaced by a single word; tail must be zeroed.
    do_start();
    load_words(1024, 1'b1, 2, 2, "ones");
    tbl[0] = 32'h1234_5678;
    do_start();
    load_words(1, 1'b1, 0, 3, "reload1");

    // Boundary: last word at address 1022 leaves exactly one fill cycle.
    do_start();
    load_words(1023, 1'b1, 0, 0, "n1023");

    // Randomized loads with random gaps.
    for (int r = 0; r < 5; r++) begin
      n = ($urandom_range(0, 3) == 0) ? 1024 : $urandom_range(1, 1023);
      l = (n < 1024) ? 1'b1 : 1'($urandom);
      do_start();
      load_words(n, l, 2, 0, $sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of a load.
    do_start();
    for (int c = 0; c < 5; c++) drive_one(1'b1, $urandom, 1'b0, 1'b0);
    chk("abort_pre_count", word_count, 5);
    #2 rst_n = 2'b00;
    #1;
    model_reset();
    chk("abort_count", word_count, 0);
    chk("abort_cpu",   cpu_rst_n, 2'b00);
    chk("abort_busy",  busy, 0);
    chk("abort_ready", word_ready, 0);
    chk("abort_trunc", trunc, 0);
    chk_img("abort_img");
    @(negedge clk);
    rst_n = 2'($urandom_range(1, 3));
    for (int c = 0; c < 5; c++) begin
      word_valid = 1'b1;
      word_data  = $urandom;
      @(negedge clk);
    end
    word_valid = 1'b0;
    chk("post_abort_busy",  busy, 0);
    chk("post_abort_done",  load_done, 0);
    chk("post_abort_count", word_count, 0);
    chk_img("post_abort_img");

    // Recovery after the aborted load.
    do_start();
    load_words(7, 1'b1, 2, 0, "recover");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
